wptr_full_ctrl: RTL

//  Write-side pointer and full-flag controller for the dual-clock async FIFO; the write-domain counterpart of the read pointer/empty logic.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/wptr_full_ctrl_sync_r2w.sv | 23 ++
 rtl/wptr_full_ctrl.sv | 72 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async FIFO sizing and Gray-code conversion helpers
package fifo_pkg;
    localparam int DEF_ADDRSIZE = 4;
    localparam int DEF_DEPTH    = 1 << DEF_ADDRSIZE;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/wptr_full_ctrl_sync_r2w.sv
// sync_r2w: two-flop synchroniser carrying the read Gray pointer into the write clock domain
module sync_r2w #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q1_q, q2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d;
            q2_q <= q1_q;
        end
    end

    assign q = q2_q;
endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: async FIFO write pointer, full/almost-full, fill count and sticky overflow
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = DEF_ADDRSIZE,
    parameter int AF_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                wovf_clr,
    output logic                wr_en,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);
    localparam int A     = ADDRSIZE;
    localparam int PW    = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] wbin_q, wbin_d, wptr_q, wptr_d, wcount_q, wcount_d, wq2_rptr, wrbin;
    logic          wfull_q, wfull_d, walmost_full_q, walmost_full_d, woverflow_q, woverflow_d;

    sync_r2w #(.W(PW)) u_sync (
        .clk(wclk),
        .rst(wrst),
        .d  (rptr),
        .q  (wq2_rptr)
    );

    // Count uses the stale synced read pointer, so fill can only be over-reported
    always_comb begin
        wr_en          = winc & ~wfull_q;
        wbin_d         = wbin_q + PW'(wr_en);
        wptr_d         = PW'(bin2gray(32'(wbin_d)));
        wrbin          = PW'(gray2bin(32'(wq2_rptr)));
        wcount_d       = wbin_d - wrbin;
        wfull_d        = wptr_d == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]};
        walmost_full_d = wcount_d >= AF_LEVEL;
        woverflow_d    = (winc & wfull_q) | (woverflow_q & ~wovf_clr);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wcount_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wcount_q       <= wcount_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[A-1:0];
    assign wptr         = wptr_q;
    assign wcount       = wcount_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign woverflow    = woverflow_q;
endmodule
